seven_display_reader: RTL and testbench
=======================================

// Module: seven_display_reader
// PURPOSE
//  Reads a 4-digit time-multiplexed, active-low 7-segment display bus.
//  Each digit pattern is decoded back to its hex nibble, and one 16-bit value is reported per complete scan.
//  It sits between the display pins (loopback/self-test or snooping a panel) and the checking logic.
//  Segment order is seg_n[6:0] = {a,b,c,d,e,f,g}, matching the team's hex-to-7seg encoder.
// PARAMETERS
//  STABLE_CYC   4     consecutive identical synced samples needed to accept a digit (>=2)
//  TIMEOUT_CYC  1024  max cycles from first capture to frame completion before discard
// PORTS
//  clk            in   1   single system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  seg_n          in   7   segment lines, active low, asynchronous to clk
//  an_n           in   4   digit enables, active low, one-hot when valid; an_n[k] selects digit k
//  value_o        out  16  {digit3,digit2,digit1,digit0} nibbles of last completed frame
//  err_o          out  4   per-digit flag: pattern of last frame not in the 16-entry table
//  frame_valid_o  out  1   1-cycle pulse; value_o/err_o updated in the same cycle
//  timeout_o      out  1   1-cycle pulse; partial frame discarded
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, capture mask 0, digit regs 0, stability counter 0, synchronizers 0.
//  Reset is honoured at any time; a partial frame is discarded and no pulse is emitted.
//  Input path: seg_n and an_n pass through a 2-flop synchronizer into an 11-bit sample s.
//  Stability counter:
//   - cnt <= (s == s_prev) ? sat(cnt+1) : 0.
//   - Capture strobe fires once, when cnt == STABLE_CYC-1.
//   - No re-capture until s changes.
//   - Capture is allowed only when an_n has exactly one 0; 1111 or multiple-low samples never capture.
//  Latency: a pin pattern held from cycle t is stored in its digit register at the edge ending cycle t+STABLE_CYC+1.
//  Decode table (seg_n -> nibble):
//   0000001->0  1001111->1  0010010->2  0000110->3
//   0000000->8  0000100->9  0001000->A  1100000->B
//   1001100->4  0100100->5  0100000->6  0001111->7
//   0110001->C  1000010->D  0110000->E  0111000->F
//   Any other pattern: nibble 0, digit error bit set, and the digit still counts as captured.
//  FSM:
//   - IDLE: first capture -> COLLECT; timer cleared.
//   - COLLECT: timer += 1 each cycle.
//     - A capture sets mask[k]. Re-capturing the same digit overwrites its nibble and error bit; latest wins.
//     - If mask becomes 4'b1111 -> EMIT. Completion has priority over timeout in the same cycle.
//     - Otherwise, timer == TIMEOUT_CYC-1 -> timeout_o=1 for 1 cycle, mask cleared, -> IDLE.
//   - EMIT (1 cycle): value_o/err_o loaded from digit regs, frame_valid_o=1, mask and timer cleared, -> IDLE.
//     - A capture arriving during EMIT is held in the digit regs.
//     - That capture sets mask on the EMIT->IDLE transition, starting the next frame (no sample lost).
//  frame_valid_o is high exactly 1 cycle after the capture that completes the mask.
//  value_o and err_o hold between frames. A timeout does not change them.
//  Scan order is free; any permutation of the 4 digits completes a frame.
// TESTING (STABLE_CYC=4, TIMEOUT_CYC=64)
//  1. Full scan, 8 cycles/digit, an_n 1110/1101/1011/0111 with 1/A/3/F
//     -> one frame_valid_o pulse, value_o=16'hF3A1, err_o=0, exactly 6 cycles after the digit3 pattern is applied.
//  2. Digit0 pattern held only 3 cycles, then an_n=1111 -> no capture, state stays IDLE.
//     Then hold it 4 cycles -> captured.
//  3. Frame with digit2 seg_n=1111111 -> value_o[11:8]=0, err_o=4'b0100.
//     Next clean frame -> err_o=0.
//  4. Scan digits 0,1 only, then an_n=1111 for 70 cycles
//     -> timeout_o pulses once, no frame_valid_o, value_o unchanged.
//     Next full frame 1/2/3/4 -> value_o=16'h4321.
//  5. an_n=1100 with a valid pattern held 20 cycles -> no capture.
//     Scan digit0 twice (5 then 7) within a frame -> value_o[3:0]=7.
//  6. Assert rst_n low after 2 digits of a frame -> all outputs 0 immediately.
//     After release, a full frame gives the correct value_o with no stale mask bits.

Source files
------------

// File: rtl/seven_display_reader.sv
// Snoops a 4-digit multiplexed active-low 7-segment bus and rebuilds the 16-bit value
// that is being displayed. One value is reported for each complete scan of the four digits.
module seven_display_reader #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] value_o,
    output logic [3:0]  err_o,
    output logic        frame_valid_o,
    output logic        timeout_o
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    logic [10:0]      sync1, s, s_prev;
    logic [CW-1:0]    cnt, cnt_next;
    logic             same, onehot, cap;
    logic [3:0]       an_low;
    logic [4:0]       dec;
    logic [3:0][3:0]  dig, dig_next;
    logic [3:0]       derr, derr_next;
    state_t           state, state_next;
    logic [3:0]       mask, mask_next, mask_hit;
    logic [TW-1:0]    timer, timer_next;
    logic             fv_next, to_next;

    // Returns {err, nibble}; unknown patterns decode to 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0000100: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b1100000: decode = 5'h0B;
            7'b0110001: decode = 5'h0C;
            7'b1000010: decode = 5'h0D;
            7'b0110000: decode = 5'h0E;
            7'b0111000: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            s      <= '0;
            s_prev <= '0;
            cnt    <= '0;
        end else begin
            sync1  <= {seg_n, an_n};
            s      <= sync1;
            s_prev <= s;
            cnt    <= cnt_next;
        end
    end

    // cnt saturates above the capture point so a held pattern strobes only once.
    always_comb begin
        same     = (s == s_prev);
        an_low   = ~s[3:0];
        onehot   = (an_low != 4'b0) && ((an_low & (an_low - 4'd1)) == 4'b0);
        cnt_next = !same ? '0 : (cnt == CW'(STABLE_CYC)) ? cnt : cnt + 1'b1;
        cap      = same && onehot && (cnt_next == CW'(STABLE_CYC - 1));
        dec      = decode(s[10:4]);
        mask_hit = cap ? an_low : 4'b0;
    end

    always_comb begin
        dig_next  = dig;
        derr_next = derr;
        for (int k = 0; k < 4; k++) begin
            if (mask_hit[k]) begin
                dig_next[k]  = dec[3:0];
                derr_next[k] = dec[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig  <= '0;
            derr <= '0;
        end else begin
            dig  <= dig_next;
            derr <= derr_next;
        end
    end

    always_comb begin
        state_next = state;
        mask_next  = mask;
        timer_next = timer;
        fv_next    = 1'b0;
        to_next    = 1'b0;
        case (state)
            IDLE: begin
                if (cap) begin
                    mask_next  = mask_hit;
                    timer_next = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                timer_next = timer + 1'b1;
                mask_next  = mask | mask_hit;
                if ((mask | mask_hit) == 4'hF) begin
                    state_next = EMIT;
                    fv_next    = 1'b1;
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    to_next    = 1'b1;
                    mask_next  = '0;
                    timer_next = '0;
                    state_next = IDLE;
                end
            end
            EMIT: begin
                // A capture landing here seeds the next frame instead of being dropped.
                timer_next = '0;
                mask_next  = mask_hit;
                state_next = cap ? COLLECT : IDLE;
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mask          <= '0;
            timer         <= '0;
            value_o       <= '0;
            err_o         <= '0;
            frame_valid_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= state_next;
            mask          <= mask_next;
            timer         <= timer_next;
            frame_valid_o <= fv_next;
            timeout_o     <= to_next;
            if (fv_next) begin
                value_o <= dig_next;
                err_o   <= derr_next;
            end
        end
    end
endmodule

// File: tb/tb_seven_display_reader.sv
// Directed bench for seven_display_reader: stimulus pushes expected frames into a queue,
// a negedge monitor pops and compares on every frame_valid_o / timeout_o pulse.
module tb_seven_display_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] value_o;
    logic [3:0]  err_o;
    logic        frame_valid_o;
    logic        timeout_o;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
        int          c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   tmo_exp = 0;
    int   cyc = 0;

    seven_display_reader #(.STABLE_CYC(4), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .value_o(value_o), .err_o(err_o),
        .frame_valid_o(frame_valid_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @cyc %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'b0000001;  4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;  4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;  4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;  4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b1100000;
            4'hC: seg_of = 7'b0110001;  4'hD: seg_of = 7'b1000010;
            4'hE: seg_of = 7'b0110000;  default: seg_of = 7'b0111000;
        endcase
    endfunction

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int k, input logic [3:0] v, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << k);
        hold(an, seg_of(v), n);
    endtask

    task automatic blank(input int n);
        hold(4'b1111, 7'b1111111, n);
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e, input int c);
        exp_t x;
        x.v = v; x.e = e; x.c = c;
        q.push_back(x);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("frame_value", value_o, x.v);
                    chk("frame_err", err_o, x.e);
                    if (x.c >= 0) chk("frame_latency", cyc, x.c);
                end
            end
            if (timeout_o) begin
                chk("unexpected_timeout", (tmo_exp > 0) ? 1 : 0, 1);
                if (tmo_exp > 0) tmo_exp--;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        an_n  = 4'b1111;
        seg_n = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_value", value_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_fv", frame_valid_o, 0);
        chk("reset_tmo", timeout_o, 0);
        rst_n = 1'b1;
        blank(4);

        // 1: full scan, latency from digit3 pattern to pulse
        digit(0, 4'h1, 8);
        digit(1, 4'hA, 8);
        digit(2, 4'h3, 8);
        push(16'hF3A1, 4'h0, cyc + 6);
        digit(3, 4'hF, 8);
        blank(6);
        drain("t1_drain");

        // 2: 3-cycle hold ignored, 4-cycle hold captured
        digit(0, 4'h2, 3);
        blank(10);
        chk("t2_short_mask", dut.mask, 4'b0000);
        digit(0, 4'h2, 4);
        blank(6);
        chk("t2_long_mask", dut.mask, 4'b0001);
        push(16'h8762, 4'h0, -1);
        digit(1, 4'h6, 8);
        digit(2, 4'h7, 8);
        digit(3, 4'h8, 8);
        blank(4);
        drain("t2_drain");

        // 3: undecodable digit2, then clean frame
        push(16'h4021, 4'b0100, -1);
        digit(0, 4'h1, 8);
        digit(1, 4'h2, 8);
        hold(4'b1011, 7'b1111111, 8);
        digit(3, 4'h4, 8);
        blank(4);
        drain("t3_err_drain");
        push(16'hDCB9, 4'h0, -1);
        digit(0, 4'h9, 8);
        digit(1, 4'hB, 8);
        digit(2, 4'hC, 8);
        digit(3, 4'hD, 8);
        blank(4);
        drain("t3_clean_drain");

        // 4: partial frame times out
        tmo_exp = 1;
        digit(0, 4'h5, 8);
        digit(1, 4'h6, 8);
        blank(70);
        chk("t4_tmo_seen", tmo_exp, 0);
        chk("t4_value_held", value_o, 16'hDCB9);
        chk("t4_mask_clear", dut.mask, 4'b0000);
        push(16'h4321, 4'h0, -1);
        digit(0, 4'h1, 8);
        digit(1, 4'h2, 8);
        digit(2, 4'h3, 8);
        digit(3, 4'h4, 8);
        blank(4);
        drain("t4_drain");

        // 5: two anodes low never captures; re-capture of digit0 wins
        hold(4'b1100, seg_of(4'h5), 20);
        blank(4);
        chk("t5_multi_mask", dut.mask, 4'b0000);
        push(16'h3217, 4'h0, -1);
        digit(0, 4'h5, 8);
        digit(1, 4'h1, 8);
        digit(0, 4'h7, 8);
        digit(2, 4'h2, 8);
        digit(3, 4'h3, 8);
        blank(4);
        drain("t5_drain");

        // 6: reset mid-frame, then out-of-order scan
        digit(0, 4'h3, 8);
        digit(1, 4'h4, 8);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_value", value_o, 0);
        chk("t6_rst_err", err_o, 0);
        chk("t6_rst_fv", frame_valid_o, 0);
        chk("t6_rst_tmo", timeout_o, 0);
        chk("t6_rst_mask", dut.mask, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        blank(4);
        push(16'hDCBA, 4'h0, -1);
        digit(2, 4'hC, 8);
        digit(3, 4'hD, 8);
        digit(0, 4'hA, 8);
        digit(1, 4'hB, 8);
        blank(4);
        drain("t6_drain");

        blank(80);
        chk("end_tmo_pending", tmo_exp, 0);
        chk("end_queue", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
